vx_cache_maint_unit: RTL and testbench

Per-bank cache maintenance sequencer. It is the parametrised successor of the bank flush walker. It accepts ranged maintenance requests in three modes: invalidate, clean, and clean+invalidate. It walks the selected lines, and the ways where needed, through a valid/ready port into the bank pipeline. It keeps the power-on tag-init sweep, and it orders completion against the MSHR and the bank drain.

---
 rtl/vx_cache_maint_unit.sv | 160 ++++++++++++++++
 tb/tb_vx_cache_maint_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_cache_maint_unit.sv
// Per-bank cache maintenance sequencer: tag-init sweep after reset,
// then ranged INV/CLEAN/CLEAN_INV walks gated by MSHR and bank drain.
module vx_cache_maint_unit #(
  parameter int BANK_ID       = 0,
  parameter int LINE_SEL_BITS = 4,
  parameter int NUM_WAYS      = 1,
  parameter int WRITEBACK     = 0,
  parameter int INIT_ON_RESET = 1,
  localparam int WAY_SEL_BITS =
    (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [LINE_SEL_BITS-1:0] req_start_line,
  input  logic [LINE_SEL_BITS:0]   req_num_lines,
  input  logic                     mshr_empty,
  input  logic                     bank_empty,
  output logic                     mnt_init,
  output logic                     mnt_valid,
  output logic [1:0]               mnt_op,
  output logic [LINE_SEL_BITS-1:0] mnt_line,
  output logic [WAY_SEL_BITS-1:0]  mnt_way,
  input  logic                     mnt_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int LW = LINE_SEL_BITS + 1;
  localparam int NL = 1 << LINE_SEL_BITS;
  localparam logic [LW-1:0] L_FULL = LW'(NL);
  localparam logic [LW-1:0] L_TOP  = LW'(NL - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [WAY_SEL_BITS-1:0] W_TOP =
    WAY_SEL_BITS'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT_MSHR,
    S_SWEEP,
    S_WAIT_BANK,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [LW-1:0]            r_line_ctr;
  logic [WAY_SEL_BITS-1:0]  r_way_ctr;
  logic [1:0]               r_op;
  logic [LINE_SEL_BITS-1:0] r_start;
  logic [LW-1:0]            r_len;
  logic                     r_iter;

  logic [1:0]    w_eff_op;
  logic [LW-1:0] w_len;
  logic          w_iter;
  logic          w_last_line;
  logic          w_last_way;

  // Clean ops only mean something when the bank can hold dirty data.
  always_comb begin
    w_eff_op = 2'd0;
    if ((WRITEBACK != 0) &&
        ((req_op == 2'd1) || (req_op == 2'd2)))
      w_eff_op = req_op;
    w_len = req_num_lines;
    if ((req_num_lines == '0) ||
        (req_num_lines >= L_FULL))
      w_len = L_FULL;
    w_iter = (w_eff_op != 2'd0) &&
             (WRITEBACK != 0) && (NUM_WAYS > 1);
  end

  assign w_last_line = (r_line_ctr == (r_len - L_ONE));
  assign w_last_way  = !r_iter || (r_way_ctr == W_TOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
      r_line_ctr <= '0;
      r_way_ctr  <= '0;
      r_op       <= '0;
      r_start    <= '0;
      r_len      <= '0;
      r_iter     <= 1'b0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_line_ctr <= r_line_ctr + L_ONE;
          if (r_line_ctr == L_TOP)
            r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_line_ctr <= '0;
          r_way_ctr  <= '0;
          if (req_valid) begin
            r_op    <= w_eff_op;
            r_start <= req_start_line;
            r_len   <= w_len;
            r_iter  <= w_iter;
            r_state <= S_WAIT_MSHR;
          end
        end
        S_WAIT_MSHR: begin
          if (mshr_empty)
            r_state <= S_SWEEP;
        end
        S_SWEEP: begin
          if (mnt_ready) begin
            if (w_last_line) begin
              r_line_ctr <= '0;
              if (w_last_way)
                r_state <= (BANK_ID == 0) ?
                           S_DONE : S_WAIT_BANK;
              else
                r_way_ctr <= r_way_ctr + 1'b1;
            end else begin
              r_line_ctr <= r_line_ctr + L_ONE;
            end
          end
        end
        S_WAIT_BANK: begin
          if (bank_empty)
            r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state registers: no input-to-output paths.
  always_comb begin
    mnt_line = '0;
    mnt_way  = '0;
    mnt_op   = 2'd0;
    unique case (1'b1)
      (r_state == S_INIT): begin
        mnt_line = r_line_ctr[LINE_SEL_BITS-1:0];
      end
      (r_state == S_SWEEP): begin
        mnt_line = r_start +
                   r_line_ctr[LINE_SEL_BITS-1:0];
        mnt_way  = r_way_ctr;
        mnt_op   = r_op;
      end
      default: begin
      end
    endcase
  end

  assign mnt_init  = (r_state == S_INIT);
  assign mnt_valid = (r_state == S_SWEEP);
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_vx_cache_maint_unit.sv
// Bench for vx_cache_maint_unit: a writeback bank-1 instance and a
// write-through bank-0 instance share stimulus, checked against a list model.
module tb_vx_cache_maint_unit;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic [1:0] req_op;
  logic [3:0] req_start_line;
  logic [4:0] req_num_lines;
  logic       mshr_empty;
  logic       bank_empty;
  logic       mnt_ready;

  logic       rr [2];
  logic       mi [2];
  logic       mv [2];
  logic [1:0] op_d [2];
  logic [3:0] ln_d [2];
  logic [1:0] wy_d [2];
  logic       bz [2];
  logic       dn [2];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q [2][$];
  int obs_q [2][$];

  vx_cache_maint_unit #(
    .BANK_ID(1), .LINE_SEL_BITS(4), .NUM_WAYS(4),
    .WRITEBACK(1), .INIT_ON_RESET(1)
  ) u_dut_wb (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rr[0]),
    .req_op(req_op), .req_start_line(req_start_line),
    .req_num_lines(req_num_lines),
    .mshr_empty(mshr_empty), .bank_empty(bank_empty),
    .mnt_init(mi[0]), .mnt_valid(mv[0]), .mnt_op(op_d[0]),
    .mnt_line(ln_d[0]), .mnt_way(wy_d[0]),
    .mnt_ready(mnt_ready), .busy(bz[0]), .done(dn[0])
  );

  vx_cache_maint_unit #(
    .BANK_ID(0), .LINE_SEL_BITS(4), .NUM_WAYS(4),
    .WRITEBACK(0), .INIT_ON_RESET(1)
  ) u_dut_wt (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(rr[1]),
    .req_op(req_op), .req_start_line(req_start_line),
    .req_num_lines(req_num_lines),
    .mshr_empty(mshr_empty), .bank_empty(bank_empty),
    .mnt_init(mi[1]), .mnt_valid(mv[1]), .mnt_op(op_d[1]),
    .mnt_line(ln_d[1]), .mnt_way(wy_d[1]),
    .mnt_ready(mnt_ready), .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int d,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h",
             tag, d, obs, exp);
    end
  endtask

  // Expected op list: ways outer, lines inner, code = op<<6|line<<2|way.
  task automatic build_exp(input int d, input int op,
                           input int st, input int num);
    int eff, len, nw, wb;
    wb  = (d == 0);
    eff = (wb && (op == 1 || op == 2)) ? op : 0;
    len = (num == 0 || num >= 16) ? 16 : num;
    nw  = (eff != 0 && wb) ? 4 : 1;
    exp_q[d].delete();
    for (int w = 0; w < nw; w++)
      for (int i = 0; i < len; i++)
        exp_q[d].push_back(eff * 64 + ((st + i) % 16) * 4 + w);
  endtask

  task automatic init_seq();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 2; d++) begin
        chk("init_line", d, {mi[d], dn[d], rr[d], ln_d[d]},
            {1'b1, 1'b0, 1'b0, 4'(i)});
      end
      @(negedge clk);
      #1;
    end
    for (int d = 0; d < 2; d++)
      chk("init_end", d, {mi[d], bz[d], rr[d]}, 3'b001);
  endtask

  task automatic run_req(input int op, input int st, input int num,
                         input int rmode, input int mh,
                         input int bh, input bit hold);
    int cnt [2];
    int last [2];
    int first [2];
    int donec [2];
    int e [2];
    logic stall [2];
    logic [31:0] pv [2];
    logic [31:0] cur;
    for (int d = 0; d < 2; d++) begin
      build_exp(d, op, st, num);
      obs_q[d].delete();
      e[d] = exp_q[d].size();
      cnt[d] = 0; last[d] = -1; first[d] = -1; donec[d] = -1;
      stall[d] = 1'b0; pv[d] = '0;
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'(op);
    req_start_line = 4'(st);
    req_num_lines = 5'(num);
    mshr_empty = (mh == 0);
    bank_empty = 1'b0;
    mnt_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("accept_rdy", d, rr[d], 1);
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      req_valid = hold && donec[0] < 0 && donec[1] < 0;
      req_op = 2'($urandom);
      req_start_line = 4'($urandom);
      req_num_lines = 5'($urandom);
      mshr_empty = (k > mh);
      bank_empty = (cnt[0] == e[0]) && (k > last[0] + bh);
      mnt_ready = (rmode == 0) ? 1'b1 :
                  (rmode == 1) ? ((k % 2) == 1) : 1'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        cur = {23'd0, mv[d], op_d[d], ln_d[d], wy_d[d]};
        if (stall[d]) chk("stall_hold", d, cur, pv[d]);
        if (mv[d] && first[d] < 0) first[d] = k;
        if (mv[d] && mnt_ready) begin
          obs_q[d].push_back(int'(cur[7:0]));
          cnt[d]++;
          last[d] = k;
        end
        stall[d] = mv[d] && !mnt_ready;
        pv[d] = cur;
        if (dn[d]) begin
          chk("done_once", d, donec[d], -1);
          donec[d] = k;
        end
        if (donec[d] < 0 || k == donec[d])
          chk("rdy_busy", d, rr[d], 0);
        if (donec[d] >= 0 && k == donec[d] + 1)
          chk("rdy_after_done", d, {bz[d], rr[d]}, 2'b01);
      end
      if (donec[0] >= 0 && donec[1] >= 0 &&
          k > donec[0] + 1 && k > donec[1] + 1) break;
    end
    for (int d = 0; d < 2; d++) begin
      chk("done_seen", d, donec[d] >= 0, 1);
      chk("n_ops", d, cnt[d], e[d]);
      chk("first_valid", d, first[d], mh + 2);
      chk("done_cyc", d, donec[d],
          (d == 0) ? last[0] + bh + 2 : last[1] + 1);
      for (int i = 0; i < e[d]; i++)
        chk("op_seq", d,
            (i < obs_q[d].size()) ? obs_q[d][i] : -1,
            exp_q[d][i]);
    end
    req_valid = 1'b0;
    mshr_empty = 1'b1;
    bank_empty = 1'b1;
  endtask

  task automatic abort_test();
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd2;
    req_start_line = 4'd3;
    req_num_lines = 5'd0;
    mshr_empty = 1'b1;
    mnt_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      mnt_ready = 1'($urandom);
    end
    #1;
    chk("abort_pre", 0, mv[0], 1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk("abort_state", d, {mv[d], dn[d], mi[d], bz[d]}, 4'b0011);
    @(negedge clk);
    init_seq();
  endtask

  initial begin
    reset_n = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_start_line = '0;
    req_num_lines = '0;
    mshr_empty = 1'b1;
    bank_empty = 1'b1;
    mnt_ready = 1'b1;
    #3;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk("reset_vals", d,
          {mi[d], bz[d], rr[d], mv[d], dn[d],
           op_d[d], ln_d[d], wy_d[d]},
          {5'b11000, 2'd0, 4'd0, 2'd0});
    init_seq();
    run_req(0, 14, 4, 0, 0, 0, 1'b0);
    run_req(2, 0, 0, 1, 0, 5, 1'b0);
    run_req(1, 5, 3, 0, 0, 0, 1'b0);
    run_req(2, 9, 20, 2, 10, 2, 1'b1);
    run_req(3, 7, 16, 2, 0, 0, 1'b0);
    repeat (8) begin
      run_req(int'($urandom_range(0, 3)),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              1'($urandom));
    end
    abort_test();
    run_req(1, 15, 16, 2, 1, 1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
